my_div_seq: RTL and testbench
=============================

MY_DIV_SEQ -- requirements
Module: my_div_seq

Interface
REQ-001 The block SHALL have no parameters; all datapaths are fixed at 32 bits.
REQ-002 clock  input  1  single clock; all state changes on its rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 data_operandA  input  32  dividend, two's complement.
REQ-005 data_operandB  input  32  divisor, two's complement.
REQ-006 ctrl_DIV  input  1  start strobe; sampled on rising edge.
REQ-007 data_result  output  32  quotient, two's complement.
REQ-008 data_remainder  output  32  remainder, two's complement.
REQ-009 data_exception  output  1  divide-by-zero or overflow flag for the current result.
REQ-010 data_resultRDY  output  1  one-cycle result-valid pulse.

Function
REQ-011 The block SHALL implement signed division: quotient truncates toward zero; remainder takes the dividend's sign; |remainder| < |divisor|.
REQ-012 Core SHALL be a 32-iteration unsigned restoring shift/subtract on operand magnitudes; one iteration per clock; signs re-applied at completion.
REQ-013 Each subtract SHALL be 33 bits wide so the borrow decides restore; no carry is lost.
REQ-014 FSM states SHALL be IDLE, RUN, DONE; IDLE is the reset state.
REQ-015 ctrl_DIV=1 on an edge in any state SHALL latch both operands, clear the iteration counter, and enter RUN; the latched copies are the only ones used.
REQ-016 An in-flight operation SHALL be abandoned without a resultRDY pulse when ctrl_DIV is reasserted.
REQ-017 RUN SHALL perform exactly 32 iterations; the 32nd iteration edge enters DONE.
REQ-018 Latency: ctrl_DIV sampled on edge k -> data_resultRDY=1 from edge k+33 to edge k+34; 1 exactly one cycle.
REQ-019 DONE SHALL last exactly one cycle; the next state is IDLE, or RUN if ctrl_DIV=1 on that edge.
REQ-020 Divisor=0 SHALL skip RUN: edge k -> DONE; resultRDY high from edge k+1 to k+2; result=0, remainder=dividend, exception=1.
REQ-021 Dividend=0x80000000 with divisor=0xFFFFFFFF SHALL follow normal latency, giving result=0x80000000, remainder=0, exception=1.
REQ-022 All other cases SHALL give exception=0.
REQ-023 data_result, data_remainder and data_exception SHALL update only on entry to DONE and hold until the next entry to DONE.
REQ-024 Operand inputs SHALL be don't-care except on the start edge.

Reset
REQ-025 reset_n=0 SHALL immediately force IDLE, counter=0, and all outputs to 0 regardless of clock.
REQ-026 Reset mid-RUN SHALL discard the operation; no resultRDY pulse SHALL follow release.
REQ-027 After reset_n rises, the first ctrl_DIV sampled on a rising edge SHALL start a normal operation.

Verification
REQ-028 100 / 7, start edge k -> resultRDY only between edges k+33 and k+34; result=14, remainder=2, exception=0.
REQ-029 -100 / 7 -> result=0xFFFFFFF2, remainder=0xFFFFFFFE; 100 / -7 -> result=0xFFFFFFF2, remainder=2; exception=0.
REQ-030 5 / 0 -> resultRDY between edges k+1 and k+2; result=0, remainder=5, exception=1.
REQ-031 0x80000000 / 0xFFFFFFFF -> result=0x80000000, remainder=0, exception=1 at normal latency; 0x80000000 / 1 -> 0x80000000, exception=0.
REQ-032 Start 100/7, then restart with 9/3 on edge k+10 -> no pulse for the first operation; pulse at k+43; result=3, remainder=0.
REQ-033 Start 100/7, drive reset_n low at k+20, release, then wait 40 cycles -> outputs all 0 and no resultRDY pulse.

Source files
------------

// File: rtl/my_div_seq.sv
// Sequential 32-bit signed divider: restoring shift/subtract on operand magnitudes,
// one quotient bit per clock, signs re-applied when the last bit is produced.
module my_div_seq (
   input  logic        clock,
   input  logic        reset_n,
   input  logic [31:0] data_operandA,
   input  logic [31:0] data_operandB,
   input  logic        ctrl_DIV,
   output logic [31:0] data_result,
   output logic [31:0] data_remainder,
   output logic        data_exception,
   output logic        data_resultRDY
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t      state, state_nxt;
   logic [31:0] a_q, b_q;
   logic [31:0] b_mag;
   logic [31:0] quo, rem;
   logic [4:0]  count;

   logic        div_zero;
   logic        last_iter;
   logic [32:0] rem_sh, diff;
   logic [31:0] quo_nxt, rem_nxt;
   logic [31:0] q_fin, r_fin;
   logic        ovf;

   function automatic logic [31:0] mag(input logic [31:0] v);
      return v[31] ? -v : v;
   endfunction

   assign div_zero  = (data_operandB == 32'd0);
   assign last_iter = (state == RUN) && (count == 5'd31);

   // One restoring step; the 33-bit difference's sign bit is the borrow.
   always_comb begin
      rem_sh  = {rem, quo[31]};
      diff    = rem_sh - {1'b0, b_mag};
      quo_nxt = {quo[30:0], 1'b0};
      rem_nxt = rem_sh[31:0];
      if (!diff[32]) begin
         quo_nxt = {quo[30:0], 1'b1};
         rem_nxt = diff[31:0];
      end
   end

   assign q_fin = (a_q[31] ^ b_q[31]) ? -quo_nxt : quo_nxt;
   assign r_fin = a_q[31] ? -rem_nxt : rem_nxt;
   assign ovf   = (a_q == 32'h8000_0000) && (b_q == 32'hFFFF_FFFF);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   // NOTE: every variable assigned here gets a default first, so no latch is inferred.
   always_comb begin
      state_nxt = state;
      if (ctrl_DIV) begin
         state_nxt = div_zero ? DONE : RUN;
      end else begin
         case (state)
            IDLE:    state_nxt = IDLE;
            RUN:     if (last_iter) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   // NOTE: clocked state uses non-blocking assignments so all registers see pre-edge values.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         a_q            <= '0;
         b_q            <= '0;
         b_mag          <= '0;
         quo            <= '0;
         rem            <= '0;
         count          <= '0;
         data_result    <= '0;
         data_remainder <= '0;
         data_exception <= 1'b0;
         data_resultRDY <= 1'b0;
      end else begin
         // The valid pulse trails the single DONE cycle by one edge.
         data_resultRDY <= (state == DONE);
         if (ctrl_DIV) begin
            a_q   <= data_operandA;
            b_q   <= data_operandB;
            quo   <= mag(data_operandA);
            b_mag <= mag(data_operandB);
            rem   <= '0;
            count <= '0;
            if (div_zero) begin
               data_result    <= '0;
               data_remainder <= data_operandA;
               data_exception <= 1'b1;
            end
         end else if (state == RUN) begin
            quo   <= quo_nxt;
            rem   <= rem_nxt;
            count <= count + 5'd1;
            if (last_iter) begin
               data_result    <= q_fin;
               data_remainder <= r_fin;
               data_exception <= ovf;
            end
         end
      end
   end

endmodule

// File: tb/tb_my_div_seq.sv
// Directed bench for my_div_seq: signed results, latency, divide-by-zero,
// overflow, restart/abandon, DONE-to-RUN back-to-back and reset behaviour.
module tb_my_div_seq;

   logic        clock = 1'b0;
   logic        reset_n = 1'b1;
   logic [31:0] data_operandA = '0;
   logic [31:0] data_operandB = '0;
   logic        ctrl_DIV = 1'b0;
   logic [31:0] data_result;
   logic [31:0] data_remainder;
   logic        data_exception;
   logic        data_resultRDY;

   int tests_run = 0;
   int tests_failed = 0;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] q;
      logic [31:0] r;
      logic        e;
      int          lat;
      string       name;
   } vec_t;

   my_div_seq dut (
      .clock          (clock),
      .reset_n        (reset_n),
      .data_operandA  (data_operandA),
      .data_operandB  (data_operandB),
      .ctrl_DIV       (ctrl_DIV),
      .data_result    (data_result),
      .data_remainder (data_remainder),
      .data_exception (data_exception),
      .data_resultRDY (data_resultRDY)
   );

   always #5 clock = ~clock;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Issues one start (caller is #1 past an edge) and observes up to max_cycles edges.
   task automatic do_div(input logic [31:0] a, input logic [31:0] b, input int max_cycles,
                         output int lat, output int pulses,
                         output logic [31:0] q, output logic [31:0] r, output logic e);
      data_operandA = a;
      data_operandB = b;
      ctrl_DIV      = 1'b1;
      @(posedge clock);
      #1;
      ctrl_DIV      = 1'b0;
      data_operandA = $urandom;
      data_operandB = $urandom;
      lat = -1; pulses = 0; q = '0; r = '0; e = 1'b0;
      for (int n = 1; n <= max_cycles; n++) begin
         @(posedge clock);
         #1;
         if (data_resultRDY) begin
            pulses++;
            if (lat < 0) begin
               lat = n;
               q = data_result;
               r = data_remainder;
               e = data_exception;
            end
         end
      end
   endtask

   task automatic test_reset;
      #1 reset_n = 1'b0;
      #2;
      tests_run++;
      if ({data_result, data_remainder, data_exception, data_resultRDY} !== 66'd0) begin
         tests_failed++;
         $display("FAIL reset_outputs: got q=%h r=%h e=%b rdy=%b required all 0",
                  data_result, data_remainder, data_exception, data_resultRDY);
      end
      repeat (3) @(posedge clock);
      #1 reset_n = 1'b1;
   endtask

   task automatic test_divide;
      vec_t vecs[$];
      int lat, pulses;
      logic [31:0] q, r;
      logic e;
      vecs.push_back('{32'd100,       32'd7,         32'd14,        32'd2,         1'b0, 33, "100/7"});
      vecs.push_back('{32'hFFFFFF9C,  32'd7,         32'hFFFFFFF2,  32'hFFFFFFFE,  1'b0, 33, "-100/7"});
      vecs.push_back('{32'd100,       32'hFFFFFFF9,  32'hFFFFFFF2,  32'd2,         1'b0, 33, "100/-7"});
      vecs.push_back('{32'hFFFFFF9C,  32'hFFFFFFF9,  32'd14,        32'hFFFFFFFE,  1'b0, 33, "-100/-7"});
      vecs.push_back('{32'd7,         32'd100,       32'd0,         32'd7,         1'b0, 33, "7/100"});
      vecs.push_back('{32'd5,         32'd0,         32'd0,         32'd5,         1'b1, 1,  "5/0"});
      vecs.push_back('{32'hFFFFFFF9,  32'd0,         32'd0,         32'hFFFFFFF9,  1'b1, 1,  "-7/0"});
      vecs.push_back('{32'h80000000,  32'hFFFFFFFF,  32'h80000000,  32'd0,         1'b1, 33, "min/-1"});
      vecs.push_back('{32'h80000000,  32'd1,         32'h80000000,  32'd0,         1'b0, 33, "min/1"});
      vecs.push_back('{32'h7FFFFFFF,  32'h80000000,  32'd0,         32'h7FFFFFFF,  1'b0, 33, "max/min"});
      vecs.push_back('{32'hFFFFFFFF,  32'hFFFFFFFF,  32'd1,         32'd0,         1'b0, 33, "-1/-1"});
      foreach (vecs[i]) begin
         do_div(vecs[i].a, vecs[i].b, 40, lat, pulses, q, r, e);
         tests_run++;
         if (lat !== vecs[i].lat) begin
            tests_failed++;
            $display("FAIL %s latency: got %0d required %0d", vecs[i].name, lat, vecs[i].lat);
         end
         tests_run++;
         if (pulses !== 1) begin
            tests_failed++;
            $display("FAIL %s pulse_count: got %0d required 1", vecs[i].name, pulses);
         end
         tests_run++;
         if (q !== vecs[i].q) begin
            tests_failed++;
            $display("FAIL %s result: got %h required %h", vecs[i].name, q, vecs[i].q);
         end
         tests_run++;
         if (r !== vecs[i].r) begin
            tests_failed++;
            $display("FAIL %s remainder: got %h required %h", vecs[i].name, r, vecs[i].r);
         end
         tests_run++;
         if (e !== vecs[i].e) begin
            tests_failed++;
            $display("FAIL %s exception: got %b required %b", vecs[i].name, e, vecs[i].e);
         end
      end
      // Outputs must still hold the last result several cycles after its pulse.
      tests_run++;
      if ({data_result, data_remainder, data_exception} !== {32'd1, 32'd0, 1'b0}) begin
         tests_failed++;
         $display("FAIL hold_outputs: got q=%h r=%h e=%b required q=1 r=0 e=0",
                  data_result, data_remainder, data_exception);
      end
   endtask

   task automatic test_restart;
      int early, lat, pulses;
      logic [31:0] q, r;
      logic e;
      early = 0;
      data_operandA = 32'd100;
      data_operandB = 32'd7;
      ctrl_DIV      = 1'b1;
      @(posedge clock);
      #1 ctrl_DIV = 1'b0;
      for (int n = 1; n <= 9; n++) begin
         @(posedge clock);
         #1;
         if (data_resultRDY) early++;
      end
      do_div(32'd9, 32'd3, 40, lat, pulses, q, r, e);
      tests_run++;
      if (early !== 0 || pulses !== 1) begin
         tests_failed++;
         $display("FAIL restart_pulses: got early=%0d second=%0d required early=0 second=1", early, pulses);
      end
      tests_run++;
      if (lat !== 33) begin
         tests_failed++;
         $display("FAIL restart_latency: got %0d required 33", lat);
      end
      tests_run++;
      if ({q, r, e} !== {32'd3, 32'd0, 1'b0}) begin
         tests_failed++;
         $display("FAIL restart_value: got q=%h r=%h e=%b required q=3 r=0 e=0", q, r, e);
      end
   endtask

   task automatic test_back_to_back;
      int lat, pulses;
      logic [31:0] mid_q;
      logic [31:0] q;
      lat = -1; pulses = 0; mid_q = '0; q = '0;
      data_operandA = 32'd100;
      data_operandB = 32'd7;
      ctrl_DIV      = 1'b1;
      @(posedge clock);
      #1 ctrl_DIV = 1'b0;
      repeat (32) @(posedge clock);
      #1;
      tests_run++;
      if (data_resultRDY !== 1'b0 || data_result !== 32'd14) begin
         tests_failed++;
         $display("FAIL done_entry: got rdy=%b q=%h required rdy=0 q=0000000e", data_resultRDY, data_result);
      end
      data_operandA = 32'hFFFFFFF7;
      data_operandB = 32'd3;
      ctrl_DIV      = 1'b1;
      @(posedge clock);
      #1 ctrl_DIV = 1'b0;
      tests_run++;
      if (data_resultRDY !== 1'b1 || data_result !== 32'd14 || data_remainder !== 32'd2) begin
         tests_failed++;
         $display("FAIL first_pulse: got rdy=%b q=%h r=%h required rdy=1 q=0000000e r=00000002",
                  data_resultRDY, data_result, data_remainder);
      end
      for (int n = 1; n <= 40; n++) begin
         @(posedge clock);
         #1;
         if (n == 10) mid_q = data_result;
         if (data_resultRDY) begin
            pulses++;
            if (lat < 0) begin
               lat = n;
               q = data_result;
            end
         end
      end
      tests_run++;
      if (mid_q !== 32'd14) begin
         tests_failed++;
         $display("FAIL hold_during_run: got %h required 0000000e", mid_q);
      end
      tests_run++;
      if (lat !== 33 || pulses !== 1 || q !== 32'hFFFFFFFD) begin
         tests_failed++;
         $display("FAIL second_op: got lat=%0d pulses=%0d q=%h required lat=33 pulses=1 q=fffffffd",
                  lat, pulses, q);
      end
   endtask

   task automatic test_reset_mid_run;
      int pulses, lat;
      logic [31:0] q, r;
      logic e;
      pulses = 0;
      data_operandA = 32'd100;
      data_operandB = 32'd7;
      ctrl_DIV      = 1'b1;
      @(posedge clock);
      #1 ctrl_DIV = 1'b0;
      repeat (20) @(posedge clock);
      #1 reset_n = 1'b0;
      #2;
      tests_run++;
      if ({data_result, data_remainder, data_exception, data_resultRDY} !== 66'd0) begin
         tests_failed++;
         $display("FAIL async_reset: got q=%h r=%h e=%b rdy=%b required all 0",
                  data_result, data_remainder, data_exception, data_resultRDY);
      end
      repeat (2) @(posedge clock);
      #1 reset_n = 1'b1;
      for (int n = 1; n <= 40; n++) begin
         @(posedge clock);
         #1;
         if (data_resultRDY) pulses++;
      end
      tests_run++;
      if (pulses !== 0 || {data_result, data_remainder, data_exception} !== 65'd0) begin
         tests_failed++;
         $display("FAIL post_reset_idle: got pulses=%0d q=%h r=%h e=%b required 0 pulses, all 0",
                  pulses, data_result, data_remainder, data_exception);
      end
      do_div(32'd100, 32'd7, 40, lat, pulses, q, r, e);
      tests_run++;
      if (lat !== 33 || pulses !== 1 || q !== 32'd14 || r !== 32'd2 || e !== 1'b0) begin
         tests_failed++;
         $display("FAIL first_after_reset: got lat=%0d pulses=%0d q=%h r=%h e=%b required lat=33 pulses=1 q=0000000e r=00000002 e=0",
                  lat, pulses, q, r, e);
      end
   endtask

   initial begin
      test_reset();
      test_divide();
      test_restart();
      test_back_to_back();
      test_reset_mid_run();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
